instr_byte_writer: RTL and testbench
====================================

Name: instr_byte_writer

Overview:
- Byte-serial program loader, write-side counterpart of the CPU's byte-wise instruction fetch.
- Accepts 32-bit instruction words over a valid/ready handshake.
- Splits each word into 4 bytes, little-endian, and writes them one byte per cycle into the 8-bit-wide instruction memory.
- Sits between a host/test loader and the instruction RAM write port; drives start/finish alongside the CPU's go/finish.

Parameters:
- ADDR_W, 10, instruction memory byte-address width (1024 bytes).
- MAX_WORDS, 256, maximum words per load session; word_cnt width = clog2(MAX_WORDS)+1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a session at base_addr
- base_addr  in  ADDR_W  first byte address; sampled on start
- num_words  in  clog2(MAX_WORDS)+1  words to load (0..MAX_WORDS); sampled on start
- word_in  in  32  instruction word
- word_valid  in  1  word_in valid
- word_ready  out  1  block can accept word_in this cycle
- mem_addr  out  ADDR_W  byte write address
- mem_wdata  out  8  byte write data
- mem_wren  out  1  byte write strobe
- busy  out  1  session active
- finish  out  1  one-cycle pulse when session ends
- overflow  out  1  sticky; address wrapped past 2^ADDR_W-1
- word_cnt  out  clog2(MAX_WORDS)+1  words fully written this session

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE.
  - All outputs 0: word_ready, mem_wren, busy, finish, overflow, word_cnt, mem_addr, mem_wdata.
  - Applies mid-session too: partial word discarded, no further writes.
- States: IDLE, WAIT_WORD, WRITE, DONE.
- IDLE:
  - On start: latch base_addr into addr_reg and num_words into remaining; clear word_cnt and overflow; busy=1.
  - If num_words==0, go to DONE; else go to WAIT_WORD.
  - Start while busy is ignored.
- WAIT_WORD:
  - word_ready=1.
  - Transfer occurs when word_valid && word_ready: latch word_in into shift register, byte_idx=0, go to WRITE.
  - word_ready is 0 in every other state.
- WRITE (4 cycles per word): each cycle drive mem_wren=1, mem_addr=addr_reg, mem_wdata=shift[7:0]; then shift right 8, addr_reg+1, byte_idx+1.
  - Byte order: byte 0 = word[7:0] at the lowest address.
  - After byte_idx==3: word_cnt+1, remaining-1.
  - If remaining becomes 0, go to DONE; else go to WAIT_WORD.
- Latency: handshake cycle N gives bytes written at N+1..N+4. Next word_ready is asserted at N+5, so peak rate is 1 word per 5 cycles.
- DONE: finish=1 for exactly one cycle, busy=0 that cycle, then IDLE.
- Address wrap:
  - addr_reg increments modulo 2^ADDR_W.
  - An increment from all-ones sets overflow (sticky until next start or rst); writing continues at address 0.
  - Overflow is set by the increment itself, even if that increment follows the final byte.
- mem_addr and mem_wdata hold their last values when mem_wren=0; only mem_wren qualifies them.
- word_valid without a session is ignored: no write, word_ready stays 0.
- start and rst in the same cycle: rst wins.
- No combinational path from word_valid to word_ready.

Decomposition:
- Shared package (loader_pkg):
  - state enum {IDLE, WAIT_WORD, WRITE, DONE}.
  - BYTES_PER_WORD=4 constant.
  - Byte-order constant LITTLE_ENDIAN=1, which instruction fetch also uses.
- One natural sub-module: word_serializer (32-bit load, 8-bit shift-out, 2-bit byte index, last_byte flag).
- FSM, address counter and session counters stay in the top.

Test Plan:
- Single word: rst; start with base_addr=0x010, num_words=1; send 0x00A00093 -> writes (0x010,0x93), (0x011,0x00), (0x012,0xA0), (0x013,0x00) on 4 consecutive cycles; finish pulses once; word_cnt=1; overflow=0.
- Back-to-back 3 words with word_valid held high -> word_ready gaps of exactly 4 cycles; 12 writes at 0x000..0x00B; finish on the cycle after the last write.
- Wrap: base_addr=0x3FE, num_words=1, word 0xDEADBEEF -> writes at 0x3FE=EF, 0x3FF=BE, 0x000=AD, 0x001=DE; overflow=1 after the 0x3FF write and stays 1 after finish.
- num_words=0 -> no mem_wren at all; finish pulses 1 cycle after start; word_ready never asserts.
- rst asserted after the 2nd byte of a word -> next cycle all outputs 0, no further mem_wren; a new start then works normally from its own base_addr.
- Stall and ignore: word_valid withheld 10 cycles in WAIT_WORD -> no writes, word_ready stays 1; start pulsed while busy -> no change to address or counts.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the byte-serial program loader and instruction fetch.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package loader_pkg;

    // Loader session states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        WRITE     = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    // Byte order shared with the byte-wise instruction fetch: byte 0 of a word
    // (bits [7:0]) lives at the lowest address.
    localparam bit LITTLE_ENDIAN  = 1'b1;

endpackage

// File: rtl/word_serializer.sv
// Loads a 32-bit word and presents it one byte at a time, tracking the byte index.
// Latency: byte 0 is visible the cycle after load; each shift exposes the next byte.
// Backpressure: none; the owner decides when to load and when to shift.
module word_serializer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] word_in,
    input  logic        shift_en,
    output logic [7:0]  byte_out,
    output logic        last_byte
);

    logic [31:0]           shift_q, shift_d;
    logic [BYTE_IDX_W-1:0] idx_q, idx_d;

    localparam logic [BYTE_IDX_W-1:0] IDX_LAST = BYTE_IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [BYTE_IDX_W-1:0] IDX_ONE  = BYTE_IDX_W'(1);

    // Next shift-register and byte-index values: load wins, otherwise shift.
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (load) begin
            shift_d = word_in;
            idx_d   = '0;
        end else if (shift_en) begin
            shift_d = LITTLE_ENDIAN ? (shift_q >> 8) : (shift_q << 8);
            idx_d   = idx_q + IDX_ONE;
        end
    end

    // Shift register and byte index state.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    assign byte_out  = LITTLE_ENDIAN ? shift_q[7:0] : shift_q[31:24];
    assign last_byte = (idx_q == IDX_LAST);

endmodule

// File: rtl/instr_byte_writer.sv
// Byte-serial instruction loader: takes 32-bit words and writes them little-endian, one byte per cycle.
// Latency: handshake in cycle N writes bytes in N+1..N+4; next word_ready in N+5 (1 word / 5 cycles).
// Backpressure: word_ready is high only while waiting for a word; it is a pure function of state.
module instr_byte_writer
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [$clog2(MAX_WORDS):0] num_words,
    input  logic [31:0]                word_in,
    input  logic                       word_valid,
    output logic                       word_ready,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [7:0]                 mem_wdata,
    output logic                       mem_wren,
    output logic                       busy,
    output logic                       finish,
    output logic                       overflow,
    output logic [$clog2(MAX_WORDS):0] word_cnt
);

    localparam int CNT_W = $clog2(MAX_WORDS) + 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [7:0]        hold_data_q, hold_data_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic              overflow_q, overflow_d;

    logic              ser_load;
    logic              ser_shift;
    logic [7:0]        ser_byte;
    logic              ser_last;
    logic              writing;

    word_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .word_in   (word_in),
        .shift_en  (ser_shift),
        .byte_out  (ser_byte),
        .last_byte (ser_last)
    );

    // Session FSM: next state, address walk and session counters.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        word_cnt_d  = word_cnt_q;
        overflow_d  = overflow_q;
        ser_load    = 1'b0;
        ser_shift   = 1'b0;
        writing     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = num_words;
                    word_cnt_d  = '0;
                    overflow_d  = 1'b0;
                    state_d     = (num_words == '0) ? DONE : WAIT_WORD;
                end
            end
            WAIT_WORD: begin
                // word_ready is high in this state, so valid alone completes the handshake.
                if (word_valid) begin
                    ser_load = 1'b1;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                writing   = 1'b1;
                ser_shift = 1'b1;
                addr_d    = addr_q + ADDR_ONE;
                // Wrapping past the top of memory is flagged even on the final byte.
                if (&addr_q) begin
                    overflow_d = 1'b1;
                end
                if (ser_last) begin
                    word_cnt_d  = word_cnt_q + CNT_ONE;
                    remaining_d = remaining_q - CNT_ONE;
                    state_d     = (remaining_q == CNT_ONE) ? DONE : WAIT_WORD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Remember the last written address/data so the memory port holds steady between writes.
    always_comb begin
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        if (writing) begin
            hold_addr_d = addr_q;
            hold_data_d = ser_byte;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            remaining_q <= '0;
            word_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            remaining_q <= remaining_d;
            word_cnt_q  <= word_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    assign word_ready = (state_q == WAIT_WORD);
    assign mem_wren   = writing;
    assign mem_addr   = writing ? addr_q   : hold_addr_q;
    assign mem_wdata  = writing ? ser_byte : hold_data_q;
    assign busy       = (state_q == WAIT_WORD) || (state_q == WRITE);
    assign finish     = (state_q == DONE);
    assign overflow   = overflow_q;
    assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_instr_byte_writer.sv
// Randomised scoreboard bench for instr_byte_writer: expected writes/finishes are queued by a model,
// a monitor on the falling edge pops and compares every write and finish.
// Inputs are driven 1ns after the rising edge.
module tb_instr_byte_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [8:0]  num_words = '0;
    logic [31:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wren;
    logic        busy;
    logic        finish;
    logic        overflow;
    logic [8:0]  word_cnt;

    instr_byte_writer #(.ADDR_W(10), .MAX_WORDS(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wren   (mem_wren),
        .busy       (busy),
        .finish     (finish),
        .overflow   (overflow),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [9:0] addr; logic [7:0] data; logic ovf; } wr_t;
    typedef struct { int n; logic ovf; } fin_t;

    wr_t         exp_wr[$];
    fin_t        exp_fin[$];
    int          hs_log[$];
    logic [31:0] words_q[$];

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_en = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected writes/finishes as the DUT presents them.
    int cyc = 0;
    int hs_cyc = -100;
    int nbyte = 0;
    int start_cyc = -100;
    int last_wr_cyc = -100;
    always @(negedge clk) begin
        wr_t  e;
        fin_t f;
        cyc++;
        if (mon_en) begin
            chk("ready_only_when_busy", word_ready && !busy, 0);
            if (start && !busy && !finish) start_cyc = cyc;
            if (word_ready && word_valid) begin
                hs_cyc = cyc;
                nbyte = 0;
                hs_log.push_back(cyc);
            end
            if (mem_wren) begin
                nbyte++;
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write_addr", mem_addr, -1);
                end else begin
                    e = exp_wr.pop_front();
                    chk("write_addr", mem_addr, e.addr);
                    chk("write_data", mem_wdata, e.data);
                    chk("overflow_during_write", overflow, e.ovf);
                    chk("write_cycle", cyc, hs_cyc + nbyte);
                end
                last_wr_cyc = cyc;
            end
            if (finish) begin
                if (exp_fin.size() == 0) begin
                    chk("unexpected_finish", 1, 0);
                end else begin
                    f = exp_fin.pop_front();
                    chk("finish_word_cnt", word_cnt, f.n);
                    chk("finish_overflow", overflow, f.ovf);
                    chk("finish_busy", busy, 0);
                    chk("finish_cycle", cyc, (f.n == 0) ? start_cyc + 1 : last_wr_cyc + 1);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [9:0] base, input int n);
        start = 1'b1;
        base_addr = base;
        num_words = 9'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic push_model(input logic [9:0] base, input int n);
        wr_t  e;
        fin_t f;
        int   idx;
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = words_q[i];
            for (int b = 0; b < 4; b++) begin
                idx = int'(base) + 4 * i + b;
                e.addr = 10'(idx % 1024);
                e.data = w[8*b +: 8];
                e.ovf  = (idx >= 1024);
                exp_wr.push_back(e);
            end
        end
        f.n = n;
        f.ovf = (n > 0) && (int'(base) + 4 * n >= 1024);
        exp_fin.push_back(f);
    endtask

    // Offer one word; optionally keep valid asserted afterwards for back-to-back transfers.
    task automatic send_word(input logic [31:0] w, input int pre_delay, input bit keep);
        bit got = 0;
        repeat (pre_delay) tick();
        word_valid = 1'b1;
        word_in = w;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (word_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("handshake_timeout", 0, 1);
        tick();
        if (!keep) word_valid = 1'b0;
    endtask

    task automatic wait_finish;
        bit got = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (finish) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("finish_timeout", 0, 1);
        tick();
    endtask

    task automatic run_session(input logic [9:0] base, input int n, input int dmax, input bit hold);
        push_model(base, n);
        pulse_start(base, n);
        for (int i = 0; i < n; i++)
            send_word(words_q[i], hold ? 0 : $urandom_range(0, dmax), hold && (i < n - 1));
        word_valid = 1'b0;
        wait_finish();
        repeat (2) tick();
    endtask

    task automatic rand_words(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_word_ready"}, word_ready, 0);
        chk({tag, "_mem_wren"}, mem_wren, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_finish"}, finish, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_word_cnt"}, word_cnt, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        wr_t e;
        int  n;
        logic [9:0] base;

        repeat (3) tick();
        rst = 1'b0;
        check_idle_outputs("reset");
        mon_en = 1;
        tick();

        // Single word.
        words_q.delete();
        words_q.push_back(32'h00A00093);
        run_session(10'h010, 1, 0, 0);

        // Back-to-back with valid held: handshakes exactly 5 cycles apart.
        hs_log.delete();
        rand_words(3);
        run_session(10'h000, 3, 0, 1);
        chk("b2b_handshakes", hs_log.size(), 3);
        if (hs_log.size() == 3) begin
            chk("b2b_gap0", hs_log[1] - hs_log[0], 5);
            chk("b2b_gap1", hs_log[2] - hs_log[1], 5);
        end

        // Address wrap.
        words_q.delete();
        words_q.push_back(32'hDEADBEEF);
        run_session(10'h3FE, 1, 0, 0);
        chk("wrap_overflow_sticky", overflow, 1);

        // Zero-word session.
        words_q.delete();
        run_session(10'h123, 0, 0, 0);

        // Reset after the second byte of a word.
        rand_words(2);
        pulse_start(10'h100, 2);
        for (int b = 0; b < 2; b++) begin
            e.addr = 10'h100 + 10'(b);
            e.data = words_q[0][8*b +: 8];
            e.ovf  = 1'b0;
            exp_wr.push_back(e);
        end
        send_word(words_q[0], 0, 0);
        tick();
        rst = 1'b1;
        tick();
        check_idle_outputs("midreset");
        rst = 1'b0;
        repeat (5) tick();
        chk("midreset_pending_writes", exp_wr.size(), 0);
        rand_words(2);
        run_session(10'h040, 2, 2, 0);

        // Stall in WAIT_WORD and ignored start while busy.
        rand_words(2);
        push_model(10'h200, 2);
        pulse_start(10'h200, 2);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            chk("stall_ready", word_ready, 1);
        end
        tick();
        pulse_start(10'h050, 7);
        for (int i = 0; i < 2; i++) send_word(words_q[i], 1, 0);
        wait_finish();
        repeat (2) tick();

        // Randomised sessions, some placed near the top of memory.
        for (int s = 0; s < 10; s++) begin
            n = $urandom_range(0, 6);
            base = (s % 3 == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom_range(0, 1023));
            rand_words(n);
            run_session(base, n, 3, ($urandom_range(0, 1) == 1));
        end

        repeat (3) tick();
        chk("leftover_writes", exp_wr.size(), 0);
        chk("leftover_finishes", exp_fin.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks done", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
